instruction_fetch: RTL

//   Producer side of the 32-bit instruction word consumed by instruction_decoder.

---
 rtl/rv_pkg.sv | 32 +++
 rtl/instruction_fetch_if.sv | 39 +++
 rtl/instruction_fetch_buffer.sv | 70 +++++++
 rtl/instruction_fetch.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 definitions used by both the fetch and the decode stages.
// Holds the canonical NOP, the base opcode map and the fetch FSM encoding.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode handshake.
// The master side is the fetch unit; the slave side is memory and decode together.
interface instruction_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/instruction_fetch_buffer.sv
// In-order buffer of fetched {instr, pc} pairs between memory responses and decode.
// Control state resets asynchronously; the storage array itself is never reset.
module fetch_buffer #(
    parameter int BUF_DEPTH = 2,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [31:0]   push_instr,
    input  logic [31:0]   push_pc,
    input  logic          pop,
    input  logic          flush,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [31:0]   head_instr,
    output logic [31:0]   head_pc
);

    localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [31:0]   instr_mem [BUF_DEPTH];
    logic [31:0]   pc_mem    [BUF_DEPTH];
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(BUF_DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(BUF_DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A push into a full buffer is only safe when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);

    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues credit-limited word requests, buffers responses in order and
// hands {instr, pc} to decode; redirects flush the buffer and drop stale responses.
module instruction_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    instruction_fetch_if.master bus
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic [31:0]   resp_pc;
    logic [31:0]   resp_pc_nxt;
    logic [31:0]   last_pc;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] in_flight_nxt;
    logic [CW-1:0] drop;
    logic [CW-1:0] drop_nxt;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic [CW+1:0] outstanding;
    logic          empty;
    logic [31:0]   head_instr;
    logic [31:0]   head_pc;
    logic          req_valid;
    logic          req_fire;
    logic          resp_live;
    logic          push;
    logic          pop;

    // Every in-flight request owns a buffer slot, so a response always finds room.
    assign credit_used = (CW+1)'(in_flight) + (CW+1)'(count);
    assign req_valid   = !rst && (state == FETCH) && !redirect_valid
                         && (credit_used < (CW+1)'(BUF_DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;
    assign resp_live   = bus.imem_resp_valid && (state == FETCH) && (in_flight != '0);
    assign push        = resp_live && !redirect_valid;
    assign pop         = !empty && bus.out_ready && !redirect_valid;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.out_valid      = !empty;
    assign bus.out_instr      = empty ? NOP_INSTR : head_instr;
    assign bus.out_pc         = empty ? last_pc : head_pc;

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH),
        .CW        (CW)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_instr (bus.imem_resp_data),
        .push_pc    (resp_pc),
        .pop        (pop),
        .flush      (redirect_valid),
        .empty      (empty),
        .count      (count),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        resp_pc_nxt   = resp_pc;
        in_flight_nxt = in_flight;
        drop_nxt      = drop;
        outstanding   = '0;

        if (redirect_valid) begin
            // Everything still owed by memory becomes stale, minus a response landing now.
            outstanding = (CW+2)'(in_flight) + (CW+2)'(drop) + (CW+2)'(req_fire);
            if (bus.imem_resp_valid && (outstanding != '0)) begin
                outstanding = outstanding - (CW+2)'(1);
            end
            fetch_pc_nxt  = word_align(redirect_pc);
            resp_pc_nxt   = word_align(redirect_pc);
            in_flight_nxt = '0;
            drop_nxt      = CW'(outstanding);
            state_nxt     = (outstanding == '0) ? FETCH : FLUSH;
        end else begin
            case (state)
                FETCH: begin
                    if (req_fire)  fetch_pc_nxt = fetch_pc + 32'd4;
                    if (resp_live) resp_pc_nxt  = resp_pc + 32'd4;
                    case ({req_fire, resp_live})
                        2'b10:   in_flight_nxt = in_flight + CW'(1);
                        2'b01:   in_flight_nxt = in_flight - CW'(1);
                        default: in_flight_nxt = in_flight;
                    endcase
                end
                FLUSH: begin
                    if (drop == '0) begin
                        state_nxt = FETCH;
                    end else if (bus.imem_resp_valid) begin
                        drop_nxt = drop - CW'(1);
                        if (drop == CW'(1)) state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            in_flight <= '0;
            drop      <= '0;
            last_pc   <= RESET_PC;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            resp_pc   <= resp_pc_nxt;
            in_flight <= in_flight_nxt;
            drop      <= drop_nxt;
            // Remembered so out_pc keeps showing the last delivered PC once drained.
            if (pop) last_pc <= head_pc;
        end
    end

    a_resp_has_request: assert property (
        @(posedge clk) disable iff (rst)
        !(bus.imem_resp_valid && (state == FETCH) && (in_flight == '0))
    );

endmodule
